// File: rtl/calc_pkg.sv
// Shared types and helpers for the sign-magnitude calculator front end.
// Operands are 3-bit sign-magnitude values; results are 4-bit sign-magnitude values.
package calc_pkg;

    localparam int OPERAND_W    = 3;
    localparam int RESULT_W     = 4;
    localparam int OPERAND_SIGN = OPERAND_W - 1;
    localparam int RESULT_SIGN  = RESULT_W - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GOT_A  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Clears the sign bit of a zero-magnitude operand, so that negative zero never reaches the adder.
    function automatic logic [OPERAND_W-1:0] norm_sm(input logic [OPERAND_W-1:0] v);
        if (v[OPERAND_SIGN-1:0] == '0) begin
            return '0;
        end
        return v;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Synchronizes a raw asynchronous button through a flop chain.
// A rising-edge detector after the chain makes a one-cycle pulse per press.
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/operand_sequencer.sv
// Captures two operands from the switch bus, holds them on the adder inputs for a settle window,
// then registers the adder result and zero flag for display.
module operand_sequencer
    import calc_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OPERAND_W-1:0] sw_value,
    input  logic                 load_btn,
    input  logic                 clear_btn,
    output logic [OPERAND_W-1:0] num1,
    output logic [OPERAND_W-1:0] num2,
    input  logic [RESULT_W-1:0]  add_result,
    input  logic                 add_zero,
    output logic [RESULT_W-1:0]  result,
    output logic                 zero,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           stage
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic load_pulse;
    logic clear_pulse;

    state_e               state_q,  state_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [OPERAND_W-1:0] num1_q,   num1_d;
    logic [OPERAND_W-1:0] num2_q,   num2_d;
    logic [RESULT_W-1:0]  result_q, result_d;
    logic                 zero_q,   zero_d;

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_load_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (load_btn),
        .pulse_o (load_pulse)
    );

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clear_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (clear_btn),
        .pulse_o (clear_pulse)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            num1_q   <= '0;
            num2_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            num1_q   <= num1_d;
            num2_q   <= num2_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        num1_d   = num1_q;
        num2_d   = num2_q;
        result_d = result_q;
        zero_d   = zero_q;

        // Clear outranks everything, including a load arriving in the same cycle.
        if (clear_pulse) begin
            state_d  = IDLE;
            cnt_d    = '0;
            num1_d   = '0;
            num2_d   = '0;
            result_d = '0;
            zero_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load_pulse) begin
                        num1_d  = norm_sm(sw_value);
                        state_d = GOT_A;
                    end
                end
                GOT_A: begin
                    if (load_pulse) begin
                        num2_d  = norm_sm(sw_value);
                        cnt_d   = '0;
                        state_d = SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q == CNT_LAST) begin
                        result_d = add_result;
                        zero_d   = add_zero;
                        state_d  = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    // Chained entry: new first operand, previous second operand and result kept.
                    if (load_pulse) begin
                        num1_d  = norm_sm(sw_value);
                        state_d = GOT_A;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign num1   = num1_q;
    assign num2   = num2_q;
    assign result = result_q;
    assign zero   = zero_q;
    assign busy   = (state_q == SETTLE);
    assign done   = (state_q == DONE);
    assign stage  = state_q;

endmodule
